timer_load_ctrl: RTL and testbench



---
 rtl/timer_pkg.sv | 34 +++
 rtl/timer_load_ctrl_if.sv | 27 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/timer_load_ctrl.sv | 135 +++++++++++++
 tb/tb_timer_load_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the mm:ss preset/count controller: state codes, BCD field layout
// and small helpers on the four-digit entry word.
package timer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ENTRY = 3'd1;
    localparam state_t ST_LOAD  = 3'd2;
    localparam state_t ST_RUN   = 3'd3;
    localparam state_t ST_PAUSE = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    localparam int DIGIT_W  = 4;
    localparam int MIN_T_LO = 12;
    localparam int MIN_U_LO = 8;
    localparam int SEC_T_LO = 4;
    localparam int SEC_U_LO = 0;

    localparam logic [3:0] SEC_T_MAX = 4'd5;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // New key enters at seconds-units; minutes-tens drops off the top.
    function automatic logic [15:0] shift_in_digit(input logic [15:0] e, input logic [3:0] d);
        return {e[MIN_T_LO-1:SEC_U_LO], d};
    endfunction

    // A preset is usable only if non-zero and its seconds-tens digit is a legal 0..5.
    function automatic logic entry_loadable(input logic [15:0] e);
        return (e != 16'h0) && (e[SEC_T_LO +: DIGIT_W] <= SEC_T_MAX)
            && (e[MIN_U_LO +: DIGIT_W] <= BCD_MAX);
    endfunction

endpackage

// File: rtl/timer_load_ctrl_if.sv
// Keypad/door side and counter-chain side signals of the load controller.
// master = the controller, slave = the environment (keypad, door switch, counter chain).
interface timer_load_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        start;
    logic        stop;
    logic        door_closed;
    logic        chain_zero;
    logic [15:0] data;
    logic        loadn;
    logic        en;
    logic        chain_clearn;
    logic [15:0] entry;
    logic        running;
    logic        done;

    modport master (
        input  key_valid, key_digit, start, stop, door_closed, chain_zero,
        output data, loadn, en, chain_clearn, entry, running, done
    );

    modport slave (
        output key_valid, key_digit, start, stop, door_closed, chain_zero,
        input  data, loadn, en, chain_clearn, entry, running, done
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk by TICK_DIV: tick is a combinational one-cycle pulse on the wrap cycle.
// Count freezes while run=0 so a paused period resumes where it left off.
module tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic clearn,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clearn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/timer_load_ctrl.sv
// Keypad entry, preset load and count-strobe control for a BCD mm:ss down-counter chain.
// All outputs are registered and change in the cycle the state they belong to is entered.
module timer_load_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = 100,
    parameter int DONE_CYCLES = 8
) (
    input logic             clk,
    input logic             clearn,
    timer_load_ctrl_if.master bus
);
    localparam int DW = $clog2(DONE_CYCLES + 1);
    localparam logic [DW-1:0] DONE_LAST = DW'(DONE_CYCLES - 1);

    state_t         state_q, state_d;
    logic [15:0]    entry_q, entry_d;
    logic [15:0]    data_q, data_d;
    logic [DW-1:0]  done_cnt_q, done_cnt_d;
    logic           first_q, first_d;
    logic           loadn_q, loadn_d;
    logic           en_q, en_d;
    logic           chain_clearn_q, chain_clearn_d;
    logic           running_q, running_d;
    logic           done_q, done_d;

    logic           key_ok;
    logic           presc_clr;
    logic           presc_run;
    logic           tick;

    assign key_ok = bus.key_valid && (bus.key_digit <= BCD_MAX);

    // Prescaler advances only on cycles that stay in RUN, so the cycle that
    // leaves for PAUSE leaves the phase untouched for the resume.
    assign presc_clr = (state_q == ST_LOAD);
    assign presc_run = (state_q == ST_RUN) && (state_d == ST_RUN);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk    (clk),
        .clearn (clearn),
        .clr    (presc_clr),
        .run    (presc_run),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!clearn) begin
            state_q        <= ST_IDLE;
            entry_q        <= 16'h0;
            data_q         <= 16'h0;
            done_cnt_q     <= '0;
            first_q        <= 1'b0;
            loadn_q        <= 1'b1;
            en_q           <= 1'b0;
            chain_clearn_q <= 1'b1;
            running_q      <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            entry_q        <= entry_d;
            data_q         <= data_d;
            done_cnt_q     <= done_cnt_d;
            first_q        <= first_d;
            loadn_q        <= loadn_d;
            en_q           <= en_d;
            chain_clearn_q <= chain_clearn_d;
            running_q      <= running_d;
            done_q         <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        done_cnt_d = done_cnt_q;
        first_d    = (state_q == ST_LOAD);
        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (bus.stop && (state_q == ST_ENTRY)) begin
                    entry_d = 16'h0;
                    state_d = ST_IDLE;
                end else if (bus.start && bus.door_closed && entry_loadable(entry_q)) begin
                    state_d = ST_LOAD;
                end else if (key_ok) begin
                    entry_d = shift_in_digit(entry_q, bus.key_digit);
                    state_d = ST_ENTRY;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                // The chain is still absorbing the preset in the first RUN cycle.
                if (bus.stop || !bus.door_closed) begin
                    state_d = ST_PAUSE;
                end else if (bus.chain_zero && !first_q) begin
                    state_d    = ST_DONE;
                    done_cnt_d = '0;
                end
            end
            ST_PAUSE: begin
                if (bus.stop) begin
                    entry_d = 16'h0;
                    state_d = ST_IDLE;
                end else if (bus.start && bus.door_closed) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.stop || bus.key_valid || (done_cnt_q == DONE_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    done_cnt_d = done_cnt_q + DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        loadn_d        = (state_d != ST_LOAD);
        data_d         = (state_d == ST_LOAD) ? entry_q : data_q;
        en_d           = tick && (state_d == ST_RUN);
        running_d      = (state_d == ST_RUN);
        done_d         = (state_d == ST_DONE);
        chain_clearn_d = !((state_q == ST_PAUSE) && (state_d == ST_IDLE));
    end

    assign bus.data         = data_q;
    assign bus.loadn        = loadn_q;
    assign bus.en           = en_q;
    assign bus.chain_clearn = chain_clearn_q;
    assign bus.entry        = entry_q;
    assign bus.running      = running_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_timer_load_ctrl.sv
// Bench for timer_load_ctrl with a behavioural mm:ss counter chain attached.
module tb_timer_load_ctrl;
    localparam int TICK_DIV    = 100;
    localparam int DONE_CYCLES = 8;

    logic clk = 1'b0;
    logic clearn;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    timer_load_ctrl_if bus ();

    timer_load_ctrl #(.TICK_DIV(TICK_DIV), .DONE_CYCLES(DONE_CYCLES)) dut (
        .clk    (clk),
        .clearn (clearn),
        .bus    (bus)
    );

    // Counter chain: time held as total seconds, converted to/from BCD mm:ss.
    logic [15:0] chain_val = 16'h0;

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        int secs, m, s;
        secs = int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
        if (secs > 0) secs = secs - 1;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    always_ff @(posedge clk) begin
        if (!bus.chain_clearn)  chain_val <= 16'h0;
        else if (!bus.loadn)    chain_val <= bus.data;
        else if (bus.en)        chain_val <= bcd_dec(chain_val);
    end
    assign bus.chain_zero = (chain_val == 16'h0);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        cyc();
        bus.key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        clearn = 1'b0;
        cyc();
        cyc();
        checks += 7;
        if (bus.entry !== 16'h0) begin errors++; $display("FAIL reset_entry got=%h exp=0000", bus.entry); end
        if (bus.data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", bus.data); end
        if (bus.loadn !== 1'b1) begin errors++; $display("FAIL reset_loadn got=%b exp=1", bus.loadn); end
        if (bus.en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", bus.en); end
        if (bus.chain_clearn !== 1'b1) begin errors++; $display("FAIL reset_chain_clearn got=%b exp=1", bus.chain_clearn); end
        if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", bus.running); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        clearn = 1'b1;
        cyc();
    endtask

    task automatic test_load_run();
        int k;
        press_key(4'd1); press_key(4'd3); press_key(4'd0);
        checks++;
        if (bus.entry !== 16'h0130) begin errors++; $display("FAIL lr_entry got=%h exp=0130", bus.entry); end
        pulse_start();
        checks += 2;
        if (bus.loadn !== 1'b0) begin errors++; $display("FAIL lr_loadn_low got=%b exp=0", bus.loadn); end
        if (bus.data !== 16'h0130) begin errors++; $display("FAIL lr_data got=%h exp=0130", bus.data); end
        cyc();
        checks += 2;
        if (bus.loadn !== 1'b1) begin errors++; $display("FAIL lr_loadn_one_cycle got=%b exp=1", bus.loadn); end
        if (bus.running !== 1'b1) begin errors++; $display("FAIL lr_running got=%b exp=1", bus.running); end
        k = 0;
        for (int i = 1; i <= 3 * TICK_DIV; i++) begin
            cyc();
            if (bus.en === 1'b1) begin k = i; break; end
        end
        checks++;
        if (k != TICK_DIV) begin errors++; $display("FAIL lr_first_en_delay got=%0d exp=%0d", k, TICK_DIV); end
        pulse_stop();
        checks++;
        if (bus.running !== 1'b0) begin errors++; $display("FAIL lr_pause_running got=%b exp=0", bus.running); end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        checks += 3;
        if (bus.chain_clearn !== 1'b0) begin errors++; $display("FAIL ss_chain_clearn got=%b exp=0", bus.chain_clearn); end
        if (bus.entry !== 16'h0) begin errors++; $display("FAIL ss_entry got=%h exp=0000", bus.entry); end
        if (bus.running !== 1'b0) begin errors++; $display("FAIL ss_running got=%b exp=0", bus.running); end
        cyc();
        checks++;
        if (bus.chain_clearn !== 1'b1) begin errors++; $display("FAIL ss_chain_clearn_one_cycle got=%b exp=1", bus.chain_clearn); end
    endtask

    task automatic test_bad_sec();
        int low_seen;
        press_key(4'd9); press_key(4'd9);
        checks++;
        if (bus.entry !== 16'h0099) begin errors++; $display("FAIL bs_entry got=%h exp=0099", bus.entry); end
        pulse_start();
        low_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.loadn !== 1'b1 || bus.running !== 1'b0) low_seen++;
            cyc();
        end
        checks += 2;
        if (low_seen != 0) begin errors++; $display("FAIL bs_start_ignored bad_cycles=%0d exp=0", low_seen); end
        if (bus.entry !== 16'h0099) begin errors++; $display("FAIL bs_entry_kept got=%h exp=0099", bus.entry); end
        pulse_stop();
        checks++;
        if (bus.entry !== 16'h0) begin errors++; $display("FAIL bs_stop_clear got=%h exp=0000", bus.entry); end
    endtask

    task automatic test_random_entry();
        int          dq[$];
        logic [15:0] exp_e;
        logic [3:0]  d;
        logic        door, exp_load;
        for (int r = 0; r < 6; r++) begin
            dq.delete();
            for (int n = 0; n < 8; n++) begin
                d = 4'($urandom_range(0, 15));
                press_key(d);
                if (d <= 4'd9) begin
                    dq.push_back(int'(d));
                    if (dq.size() > 4) void'(dq.pop_front());
                end
                exp_e = 16'h0;
                foreach (dq[j]) exp_e = (exp_e << 4) | 16'(dq[j]);
                checks++;
                if (bus.entry !== exp_e) begin errors++; $display("FAIL re_entry r=%0d n=%0d got=%h exp=%h", r, n, bus.entry, exp_e); end
            end
            door = 1'($urandom_range(0, 1));
            bus.door_closed = door;
            exp_load = door && (exp_e != 16'h0) && (exp_e[7:4] <= 4'd5);
            pulse_start();
            checks++;
            if (bus.loadn !== !exp_load) begin errors++; $display("FAIL re_load r=%0d entry=%h door=%b got_loadn=%b exp=%b", r, exp_e, door, bus.loadn, !exp_load); end
            if (exp_load) begin
                cyc();
                pulse_stop();
            end
            pulse_stop();
            bus.door_closed = 1'b1;
            checks++;
            if (bus.entry !== 16'h0) begin errors++; $display("FAIL re_cleared r=%0d got=%h exp=0000", r, bus.entry); end
        end
    endtask

    task automatic test_door_pause();
        int p, k, en_bad;
        press_key(4'd2); press_key(4'd0); press_key(4'd0);
        pulse_start();
        cyc();
        for (int it = 0; it < 2; it++) begin
            p = (it == 0) ? 50 : $urandom_range(5, 95);
            en_bad = 0;
            for (int j = 0; j < p; j++) begin
                cyc();
                if (bus.en !== 1'b0) en_bad++;
            end
            bus.door_closed = 1'b0;
            cyc();
            checks++;
            if (bus.running !== 1'b0) begin errors++; $display("FAIL dp_paused it=%0d got=%b exp=0", it, bus.running); end
            for (int j = 0; j < 6; j++) begin
                if (bus.en !== 1'b0) en_bad++;
                cyc();
            end
            checks++;
            if (en_bad != 0) begin errors++; $display("FAIL dp_en_quiet it=%0d bad_cycles=%0d exp=0", it, en_bad); end
            bus.door_closed = 1'b1;
            pulse_start();
            checks++;
            if (bus.running !== 1'b1) begin errors++; $display("FAIL dp_resumed it=%0d got=%b exp=1", it, bus.running); end
            k = 0;
            for (int i = 1; i <= 3 * TICK_DIV; i++) begin
                cyc();
                if (bus.en === 1'b1) begin k = i; break; end
            end
            checks++;
            if (k != TICK_DIV - p) begin errors++; $display("FAIL dp_resume_en it=%0d p=%0d got=%0d exp=%0d", it, p, k, TICK_DIV - p); end
        end
        pulse_stop();
        pulse_stop();
    endtask

    task automatic test_done();
        int t, n_en, last_en, first_done, dcnt, en_bad;
        press_key(4'd2);
        pulse_start();
        cyc();
        n_en = 0; last_en = -100; first_done = -1;
        for (t = 0; t < 5 * TICK_DIV; t++) begin
            cyc();
            if (bus.en === 1'b1) begin n_en++; last_en = t; end
            if (bus.done === 1'b1) begin first_done = t; break; end
        end
        checks += 4;
        if (n_en != 2) begin errors++; $display("FAIL dn_en_count got=%0d exp=2", n_en); end
        if (first_done - last_en != 2) begin errors++; $display("FAIL dn_latency got=%0d exp=2", first_done - last_en); end
        if (bus.running !== 1'b0) begin errors++; $display("FAIL dn_running got=%b exp=0", bus.running); end
        if (bus.en !== 1'b0) begin errors++; $display("FAIL dn_en got=%b exp=0", bus.en); end
        dcnt = (first_done >= 0) ? 1 : 0;
        en_bad = 0;
        for (int i = 0; i < 4 * DONE_CYCLES && first_done >= 0; i++) begin
            cyc();
            if (bus.en !== 1'b0) en_bad++;
            if (bus.done === 1'b1) dcnt++;
            else break;
        end
        checks += 3;
        if (dcnt != DONE_CYCLES) begin errors++; $display("FAIL dn_width got=%0d exp=%0d", dcnt, DONE_CYCLES); end
        if (en_bad != 0) begin errors++; $display("FAIL dn_en_quiet bad_cycles=%0d exp=0", en_bad); end
        if (bus.entry !== 16'h0002) begin errors++; $display("FAIL dn_entry_kept got=%h exp=0002", bus.entry); end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        checks += 2;
        if (bus.loadn !== 1'b0) begin errors++; $display("FAIL rr_reload_loadn got=%b exp=0", bus.loadn); end
        if (bus.data !== 16'h0002) begin errors++; $display("FAIL rr_reload_data got=%h exp=0002", bus.data); end
        cyc();
        for (int i = 0; i < 30; i++) cyc();
        checks++;
        if (bus.running !== 1'b1) begin errors++; $display("FAIL rr_running got=%b exp=1", bus.running); end
        clearn = 1'b0;
        cyc();
        checks += 5;
        if (bus.running !== 1'b0) begin errors++; $display("FAIL rr_running_reset got=%b exp=0", bus.running); end
        if (bus.loadn !== 1'b1) begin errors++; $display("FAIL rr_loadn got=%b exp=1", bus.loadn); end
        if (bus.en !== 1'b0) begin errors++; $display("FAIL rr_en got=%b exp=0", bus.en); end
        if (bus.entry !== 16'h0) begin errors++; $display("FAIL rr_entry got=%h exp=0000", bus.entry); end
        if (bus.data !== 16'h0) begin errors++; $display("FAIL rr_data got=%h exp=0000", bus.data); end
        clearn = 1'b1;
        cyc();
        pulse_start();
        checks++;
        if (bus.loadn !== 1'b1) begin errors++; $display("FAIL rr_idle_start got=%b exp=1", bus.loadn); end
        press_key(4'd5);
        press_key(4'd12);
        checks++;
        if (bus.entry !== 16'h0005) begin errors++; $display("FAIL rr_entry_after got=%h exp=0005", bus.entry); end
    endtask

    initial begin
        clearn          = 1'b0;
        bus.key_valid   = 1'b0;
        bus.key_digit   = 4'd0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.door_closed = 1'b1;
        test_reset();
        test_load_run();
        test_bad_sec();
        test_random_entry();
        test_door_pause();
        test_done();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
